// File: rtl/ifu_inst_align_if.sv
// Fetch-side bundle for the instruction aligner: request tracking, R-channel beats,
// decode handshake and the credit stall back to the PC stage.
interface ifu_inst_align_if #(
    parameter int ADDR_W = 32
);
    logic              flush_i;
    logic              req_valid_i;
    logic [ADDR_W-1:0] req_pc_i;
    logic              rsp_valid_i;
    logic [63:0]       rsp_data_i;
    logic              rsp_ready_o;
    logic              inst_valid_o;
    logic [31:0]       inst_o;
    logic [ADDR_W-1:0] inst_pc_o;
    logic              inst_ready_i;
    logic              stall_fetch_o;

    modport master (
        output flush_i, req_valid_i, req_pc_i, rsp_valid_i, rsp_data_i, inst_ready_i,
        input  rsp_ready_o, inst_valid_o, inst_o, inst_pc_o, stall_fetch_o
    );

    modport slave (
        input  flush_i, req_valid_i, req_pc_i, rsp_valid_i, rsp_data_i, inst_ready_i,
        output rsp_ready_o, inst_valid_o, inst_o, inst_pc_o, stall_fetch_o
    );
endinterface

// File: rtl/ifu_inst_align.sv
// Fetch-response aligner: tracks issued fetch PCs, buffers 64-bit beats and hands
// them to decode as 32-bit instructions, dropping stale beats after a flush.
module ifu_inst_align #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic           clk,
    input  logic           rst,
    ifu_inst_align_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 2;

    logic [ADDR_W-1:0] tag_mem [DEPTH];
    logic [PW-1:0]     tag_wr_ptr_reg, tag_wr_ptr_next;
    logic [PW-1:0]     tag_rd_ptr_reg, tag_rd_ptr_next;
    logic [CW-1:0]     tag_cnt_reg, tag_cnt_next;

    logic [63:0]       beat_data_mem [DEPTH];
    logic [ADDR_W-1:0] beat_pc_mem [DEPTH];
    logic [PW-1:0]     beat_wr_ptr_reg, beat_wr_ptr_next;
    logic [PW-1:0]     beat_rd_ptr_reg, beat_rd_ptr_next;
    logic [CW-1:0]     beat_cnt_reg, beat_cnt_next;

    logic [CW-1:0]     drop_cnt_reg, drop_cnt_next;
    logic              slot_adv_reg, slot_adv_next;

    logic              tag_push, rsp_live, rsp_drop, inst_valid, inst_fire, beat_pop, slot_sel;
    logic [63:0]       head_data;
    logic [ADDR_W-1:0] head_pc;
    logic [OW-1:0]     outstanding, drop_sum, drop_flush;
    logic              unused_head_lsb;

    assign tag_push   = bus.req_valid_i;
    assign rsp_live   = bus.rsp_valid_i & ~bus.flush_i & (drop_cnt_reg == '0);
    assign rsp_drop   = bus.rsp_valid_i & ~bus.flush_i & (drop_cnt_reg != '0);
    assign inst_valid = (beat_cnt_reg != '0);
    assign inst_fire  = inst_valid & bus.inst_ready_i & ~bus.flush_i;

    // Small buffer read asynchronously so a beat is presented the cycle after it lands.
    assign head_data = beat_data_mem[beat_rd_ptr_reg];
    assign head_pc   = beat_pc_mem[beat_rd_ptr_reg];
    assign slot_sel  = head_pc[2] | slot_adv_reg;
    assign beat_pop  = inst_fire & slot_sel;
    assign unused_head_lsb = ^head_pc[1:0];

    // Everything still owed to us by the bus or sitting in the buffer consumes a credit.
    assign outstanding = OW'(tag_cnt_reg) + OW'(beat_cnt_reg) + OW'(drop_cnt_reg);
    assign drop_sum    = OW'(drop_cnt_reg) + OW'(tag_cnt_reg);
    assign drop_flush  = (bus.rsp_valid_i && drop_sum != '0) ? drop_sum - OW'(1) : drop_sum;

    assign bus.rsp_ready_o   = 1'b1;
    assign bus.inst_valid_o  = inst_valid;
    assign bus.inst_o        = inst_valid ? (slot_sel ? head_data[63:32] : head_data[31:0]) : '0;
    assign bus.inst_pc_o     = inst_valid ? {head_pc[ADDR_W-1:3], slot_sel, 2'b00} : '0;
    assign bus.stall_fetch_o = (outstanding >= OW'(DEPTH));

    always_comb begin
        tag_wr_ptr_next  = tag_push ? tag_wr_ptr_reg + PW'(1) : tag_wr_ptr_reg;
        tag_rd_ptr_next  = tag_rd_ptr_reg;
        tag_cnt_next     = tag_cnt_reg;
        beat_wr_ptr_next = rsp_live ? beat_wr_ptr_reg + PW'(1) : beat_wr_ptr_reg;
        beat_rd_ptr_next = beat_rd_ptr_reg;
        beat_cnt_next    = beat_cnt_reg;
        drop_cnt_next    = drop_cnt_reg;
        slot_adv_next    = slot_adv_reg;

        if (bus.flush_i) begin
            // A fetch issued alongside the flush starts the new stream in the emptied FIFO.
            tag_rd_ptr_next  = tag_wr_ptr_reg;
            tag_cnt_next     = tag_push ? CW'(1) : '0;
            beat_rd_ptr_next = beat_wr_ptr_reg;
            beat_cnt_next    = '0;
            drop_cnt_next    = CW'(drop_flush);
            slot_adv_next    = 1'b0;
        end else begin
            if (rsp_live) tag_rd_ptr_next = tag_rd_ptr_reg + PW'(1);
            case ({tag_push, rsp_live})
                2'b10:   tag_cnt_next = tag_cnt_reg + CW'(1);
                2'b01:   tag_cnt_next = tag_cnt_reg - CW'(1);
                default: tag_cnt_next = tag_cnt_reg;
            endcase

            if (beat_pop) beat_rd_ptr_next = beat_rd_ptr_reg + PW'(1);
            case ({rsp_live, beat_pop})
                2'b10:   beat_cnt_next = beat_cnt_reg + CW'(1);
                2'b01:   beat_cnt_next = beat_cnt_reg - CW'(1);
                default: beat_cnt_next = beat_cnt_reg;
            endcase

            if (rsp_drop) drop_cnt_next = drop_cnt_reg - CW'(1);
            // Low word delivered: move to the high word; high word delivered: next beat.
            if (inst_fire) slot_adv_next = ~slot_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_push) tag_mem[tag_wr_ptr_reg] <= bus.req_pc_i;
        if (rsp_live) begin
            beat_data_mem[beat_wr_ptr_reg] <= bus.rsp_data_i;
            beat_pc_mem[beat_wr_ptr_reg]   <= tag_mem[tag_rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wr_ptr_reg  <= '0;
            tag_rd_ptr_reg  <= '0;
            tag_cnt_reg     <= '0;
            beat_wr_ptr_reg <= '0;
            beat_rd_ptr_reg <= '0;
            beat_cnt_reg    <= '0;
            drop_cnt_reg    <= '0;
            slot_adv_reg    <= 1'b0;
        end else begin
            tag_wr_ptr_reg  <= tag_wr_ptr_next;
            tag_rd_ptr_reg  <= tag_rd_ptr_next;
            tag_cnt_reg     <= tag_cnt_next;
            beat_wr_ptr_reg <= beat_wr_ptr_next;
            beat_rd_ptr_reg <= beat_rd_ptr_next;
            beat_cnt_reg    <= beat_cnt_next;
            drop_cnt_reg    <= drop_cnt_next;
            slot_adv_reg    <= slot_adv_next;
        end
    end
endmodule
